// File: rtl/dsp_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Package : dsp_bridge_pkg
// Brief   : Shared widths and writer-FSM state type for dsp_host_bridge.
// Rev     : 1.0 - initial release
// ============================================================================
package dsp_bridge_pkg;

  localparam int DSP_ADDR_W  = 8;
  localparam int DSP_DATA_W  = 8;
  localparam int TIMESTAMP_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STROBE = 2'd2
  } wr_state_e;

endpackage
`default_nettype wire

// File: rtl/dsp_host_bridge_if.sv
`default_nettype none
// ============================================================================
// Interface : dsp_host_bridge_if
// Brief     : Host register, DSP and capture-consumer signals of the bridge.
// Config    : DSP_CAPTURE_TIMESTAMP_EN adds cap_timestamp.
// Rev       : 1.0 - initial release
// ============================================================================
interface dsp_host_bridge_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int CHANNELS     = 2,
  parameter int CAP_DEPTH    = 16
);
  import dsp_bridge_pkg::*;

  logic                             host_reg_valid;
  logic                             host_reg_ready;
  logic [DSP_ADDR_W-1:0]            host_reg_address;
  logic [DSP_DATA_W-1:0]            host_reg_data;
  logic [DSP_ADDR_W-1:0]            dsp_reg_address;
  logic [DSP_DATA_W-1:0]            dsp_reg_data;
  logic                             dsp_reg_write_enable;
  logic                             dsp_idle;
  logic                             dsp_audio_valid;
  logic [CHANNELS*SAMPLE_WIDTH-1:0] dsp_audio;
  logic                             capture_enable;
  logic                             cap_valid;
  logic                             cap_ready;
  logic [CHANNELS*SAMPLE_WIDTH-1:0] cap_data;
  logic [$clog2(CAP_DEPTH):0]       cap_count;
  logic                             cap_overflow;
  logic                             clear_overflow;
`ifdef DSP_CAPTURE_TIMESTAMP_EN
  logic [TIMESTAMP_W-1:0]           cap_timestamp;
`endif

  modport master (
`ifdef DSP_CAPTURE_TIMESTAMP_EN
    input  cap_timestamp,
`endif
    output host_reg_valid, host_reg_address, host_reg_data, dsp_idle,
           dsp_audio_valid, dsp_audio, capture_enable, cap_ready, clear_overflow,
    input  host_reg_ready, dsp_reg_address, dsp_reg_data, dsp_reg_write_enable,
           cap_valid, cap_data, cap_count, cap_overflow
  );

  modport slave (
`ifdef DSP_CAPTURE_TIMESTAMP_EN
    output cap_timestamp,
`endif
    input  host_reg_valid, host_reg_address, host_reg_data, dsp_idle,
           dsp_audio_valid, dsp_audio, capture_enable, cap_ready, clear_overflow,
    output host_reg_ready, dsp_reg_address, dsp_reg_data, dsp_reg_write_enable,
           cap_valid, cap_data, cap_count, cap_overflow
  );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO with registered occupancy; push on full is
//          accepted only when a pop frees a slot in the same cycle.
// Rev    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  i_push,
  input  wire logic                  i_pop,
  input  wire logic [WIDTH-1:0]      i_wdata,
  output logic      [WIDTH-1:0]      o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic      [$clog2(DEPTH):0] o_count
);
  localparam int                  c_addr_w = $clog2(DEPTH);
  localparam logic [c_addr_w:0]   c_cnt_one = 1;
  localparam logic [c_addr_w-1:0] c_ptr_one = 1;

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_addr_w:0]   r_count;
  logic                w_do_push;
  logic                w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == DEPTH[c_addr_w:0]);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers are exactly log2(DEPTH) wide, so wrap is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dsp_host_bridge.sv
`default_nettype none
// ============================================================================
// Module : dsp_host_bridge
// Brief  : Queues host register writes toward an idle-gated DSP and buffers
//          DAC frames for a valid/ready consumer with overflow reporting.
// Config : DSP_CAPTURE_TIMESTAMP_EN adds a per-frame 16-bit cap_timestamp.
// Rev    : 1.0 - initial release
// ============================================================================
module dsp_host_bridge
  import dsp_bridge_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int CHANNELS     = 2,
  parameter int CAP_DEPTH    = 16,
  parameter int REGQ_DEPTH   = 4
) (
  input wire logic          clock,
  input wire logic          reset,
  dsp_host_bridge_if.slave  bus
);
  localparam int c_frame_w = CHANNELS * SAMPLE_WIDTH;
`ifdef DSP_CAPTURE_TIMESTAMP_EN
  localparam int c_cap_w   = c_frame_w + TIMESTAMP_W;
`else
  localparam int c_cap_w   = c_frame_w;
`endif
  localparam int                  c_q_w     = DSP_ADDR_W + DSP_DATA_W;
  localparam int                  c_qcnt_w  = $clog2(REGQ_DEPTH) + 1;
  localparam logic [c_qcnt_w-1:0] c_q_one   = 1;

  // ---------------- register write queue and writer FSM ----------------
  logic                r_ready_en;
  logic                w_q_push;
  logic                w_q_pop;
  logic                w_q_full;
  logic                w_q_empty;
  logic [c_q_w-1:0]    w_q_rdata;
  logic [c_qcnt_w-1:0] w_q_count;
  wr_state_e           r_state;
  wr_state_e           w_state_next;
  logic                w_latch;
  logic [c_q_w-1:0]    r_dsp_word;

  // Ready is held low for one cycle after reset release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_ready_en <= 1'b0;
    else        r_ready_en <= 1'b1;
  end

  assign bus.host_reg_ready = r_ready_en && !w_q_full;
  assign w_q_push           = bus.host_reg_valid && bus.host_reg_ready;

  sync_fifo #(.WIDTH(c_q_w), .DEPTH(REGQ_DEPTH)) u_regq (
    .clk     (clock),
    .rst_n   (reset),
    .i_push  (w_q_push),
    .i_pop   (w_q_pop),
    .i_wdata ({bus.host_reg_address, bus.host_reg_data}),
    .o_rdata (w_q_rdata),
    .o_full  (w_q_full),
    .o_empty (w_q_empty),
    .o_count (w_q_count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    unique case (r_state)
      IDLE:   if (!w_q_empty) w_state_next = WAIT;
      WAIT:   if (bus.dsp_idle) begin
                w_state_next = STROBE;
                w_latch      = 1'b1;
              end
      STROBE: w_state_next = ((w_q_count > c_q_one) || w_q_push) ? WAIT : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_q_pop                  = (r_state == STROBE);
  assign bus.dsp_reg_write_enable = (r_state == STROBE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       r_dsp_word <= '0;
    else if (w_latch) r_dsp_word <= w_q_rdata;
  end

  assign bus.dsp_reg_address = r_dsp_word[c_q_w-1:DSP_DATA_W];
  assign bus.dsp_reg_data    = r_dsp_word[DSP_DATA_W-1:0];

  // ---------------- capture FIFO ----------------
  logic               w_c_push;
  logic               w_c_pop;
  logic               w_c_full;
  logic               w_c_empty;
  logic               w_ovf_evt;
  logic [c_cap_w-1:0] w_c_wdata;
  logic [c_cap_w-1:0] w_c_rdata;
  logic               r_overflow;

  assign w_c_push  = bus.capture_enable && bus.dsp_audio_valid;
  assign w_c_pop   = !w_c_empty && bus.cap_ready;
  assign w_ovf_evt = w_c_push && w_c_full && !w_c_pop;

`ifdef DSP_CAPTURE_TIMESTAMP_EN
  logic [TIMESTAMP_W-1:0] r_ts;

  // Counts every presented frame, including those not captured.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                   r_ts <= '0;
    else if (bus.dsp_audio_valid) r_ts <= r_ts + 1'b1;
  end

  assign w_c_wdata         = {r_ts, bus.dsp_audio};
  assign bus.cap_timestamp = w_c_empty ? '0 : w_c_rdata[c_frame_w +: TIMESTAMP_W];
`else
  assign w_c_wdata         = bus.dsp_audio;
`endif

  sync_fifo #(.WIDTH(c_cap_w), .DEPTH(CAP_DEPTH)) u_capq (
    .clk     (clock),
    .rst_n   (reset),
    .i_push  (w_c_push),
    .i_pop   (w_c_pop),
    .i_wdata (w_c_wdata),
    .o_rdata (w_c_rdata),
    .o_full  (w_c_full),
    .o_empty (w_c_empty),
    .o_count (bus.cap_count)
  );

  assign bus.cap_valid = !w_c_empty;
  assign bus.cap_data  = w_c_empty ? '0 : w_c_rdata[c_frame_w-1:0];

  // A fresh drop outranks a same-cycle clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                  r_overflow <= 1'b0;
    else if (w_ovf_evt)          r_overflow <= 1'b1;
    else if (bus.clear_overflow) r_overflow <= 1'b0;
  end

  assign bus.cap_overflow = r_overflow;

endmodule
`default_nettype wire
